// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT transmit and receive paths.
// Frame state encoding, idle line level and parity helper.
package usrt_pkg;

   localparam int FRAME_DATA_W = 8;

   localparam logic TX_IDLE = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } usrtState_t;

   // Even parity is the XOR of the data bits; odd is its inverse.
   function automatic logic calcParity(
      input logic [FRAME_DATA_W-1:0] data,
      input logic                    odd
   );
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/usrt_tx_buf.sv
// One-entry holding buffer between the APB data register and the framer.
// Tracks occupancy, accepts writes only when empty, flags dropped writes.
module usrt_tx_buf
   import usrt_pkg::*;
(
   input  logic                    pClk,
   input  logic                    pReset,
   input  logic                    wrEn,
   input  logic [FRAME_DATA_W-1:0] wrData,
   input  logic                    ovrClr,
   input  logic                    drain,
   output logic                    ready,
   output logic                    bufFull,
   output logic [FRAME_DATA_W-1:0] bufData,
   output logic                    overrun
);

   logic full;
   logic [FRAME_DATA_W-1:0] data;
   logic ovr;
   logic accept;

   // A write lands only in an empty buffer; a drain frees it.
   assign accept = wrEn && !full;

   // Occupancy and payload; load and drain never coincide.
   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         full <= 1'b0;
         data <= '0;
      end else if (accept) begin
         full <= 1'b1;
         data <= wrData;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

   // Sticky drop flag; a new drop beats a same-cycle clear.
   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         ovr <= 1'b0;
      end else if (wrEn && full) begin
         ovr <= 1'b1;
      end else if (ovrClr) begin
         ovr <= 1'b0;
      end
   end

   assign ready   = !full;
   assign bufFull = full;
   assign bufData = data;
   assign overrun = ovr;

endmodule

// File: rtl/usrt_tx.sv
// USRT transmit framer: start, 8 data LSB-first, optional parity, stop.
// Bit timing follows baud_tick; back-to-back frames have no idle gap.
module usrt_tx
   import usrt_pkg::*;
#(
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                    pClk,
   input  logic                    pReset,
   input  logic                    baud_tick,
   input  logic                    wr_en,
   input  logic [FRAME_DATA_W-1:0] wr_data,
   output logic                    ready,
   output logic                    busy,
   output logic                    tx,
   output logic                    tx_done,
   input  logic                    ovr_clr,
   output logic                    overrun
);

   localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_W - 1);

   usrtState_t state;
   usrtState_t stateNxt;

   logic [FRAME_DATA_W-1:0] shiftReg;
   logic [FRAME_DATA_W-1:0] shiftNxt;
   logic                    parityBit;
   logic                    parityNxt;
   logic [2:0]              bitCnt;
   logic [2:0]              bitCntNxt;
   logic                    txReg;
   logic                    txNxt;
   logic                    txDone;

   logic                    drain;
   logic                    bufFull;
   logic [FRAME_DATA_W-1:0] bufData;

   usrt_tx_buf uBuf (
      .pClk    (pClk),
      .pReset  (pReset),
      .wrEn    (wr_en),
      .wrData  (wr_data),
      .ovrClr  (ovr_clr),
      .drain   (drain),
      .ready   (ready),
      .bufFull (bufFull),
      .bufData (bufData),
      .overrun (overrun)
   );

   // State, shifter and registered line level.
   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         state     <= IDLE;
         shiftReg  <= '0;
         parityBit <= 1'b0;
         bitCnt    <= '0;
         txReg     <= TX_IDLE;
      end else begin
         state     <= stateNxt;
         shiftReg  <= shiftNxt;
         parityBit <= parityNxt;
         bitCnt    <= bitCntNxt;
         txReg     <= txNxt;
      end
   end

   // Next-state and datapath; every change waits for a baud tick.
   always_comb begin
      stateNxt  = state;
      shiftNxt  = shiftReg;
      parityNxt = parityBit;
      bitCntNxt = bitCnt;
      txNxt     = txReg;
      drain     = 1'b0;
      txDone    = 1'b0;
      unique case (state)
         IDLE: begin
            if (baud_tick && bufFull) begin
               drain     = 1'b1;
               shiftNxt  = bufData;
               parityNxt = calcParity(bufData, PARITY_ODD);
               txNxt     = 1'b0;
               stateNxt  = START;
            end else if (baud_tick) begin
               txNxt = TX_IDLE;
            end
         end
         START: begin
            if (baud_tick) begin
               txNxt     = shiftReg[0];
               bitCntNxt = '0;
               stateNxt  = DATA;
            end
         end
         DATA: begin
            if (baud_tick && bitCnt == LAST_BIT) begin
               if (PARITY_EN) begin
                  txNxt    = parityBit;
                  stateNxt = PARITY;
               end else begin
                  txNxt    = TX_IDLE;
                  stateNxt = STOP;
               end
            end else if (baud_tick) begin
               shiftNxt  = shiftReg >> 1;
               txNxt     = shiftReg[1];
               bitCntNxt = bitCnt + 3'd1;
            end
         end
         PARITY: begin
            if (baud_tick) begin
               txNxt    = TX_IDLE;
               stateNxt = STOP;
            end
         end
         STOP: begin
            if (baud_tick) begin
               txDone = 1'b1;
               if (bufFull) begin
                  drain     = 1'b1;
                  shiftNxt  = bufData;
                  parityNxt = calcParity(bufData, PARITY_ODD);
                  txNxt     = 1'b0;
                  stateNxt  = START;
               end else begin
                  txNxt    = TX_IDLE;
                  stateNxt = IDLE;
               end
            end
         end
         default: begin
            txNxt    = TX_IDLE;
            stateNxt = IDLE;
         end
      endcase
   end

   assign tx      = txReg;
   assign tx_done = txDone;
   assign busy    = (state != IDLE) || bufFull;

endmodule
